// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - fetch-to-decode buffer with registered head output
// Define IF_ID_SKID_EN for the two-entry skid buffer; otherwise a single entry is used.
module if_id_buf #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        jump_en_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  input  logic        ready_i
);

  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] head_addr_q, head_addr_d;
  logic [31:0] head_inst_q, head_inst_d;
`ifdef IF_ID_SKID_EN
  logic [31:0] tail_addr_q, tail_addr_d;
  logic [31:0] tail_inst_q, tail_inst_d;
`endif
  logic        push, pop;

  assign valid_o     = valid_q;
  assign inst_o      = head_inst_q;
  assign inst_addr_o = head_addr_q;

`ifdef IF_ID_SKID_EN
  assign ready_o = (count_q != 2'd2);
`else
  assign ready_o = ~valid_q | ready_i;
`endif

  assign push = valid_i & ready_o & ~jump_en_i;
  assign pop  = valid_q & ready_i;

  always_comb begin
    count_d     = count_q;
    head_addr_d = head_addr_q;
    head_inst_d = head_inst_q;
`ifdef IF_ID_SKID_EN
    tail_addr_d = tail_addr_q;
    tail_inst_d = tail_inst_q;
`endif
    if (jump_en_i) begin
      count_d     = 2'd0;
      head_addr_d = RST_ADDR;
      head_inst_d = NOP_INST;
    end else if (pop && push) begin
      // Only reachable with one entry held: the incoming beat replaces the head.
      head_addr_d = inst_addr_i;
      head_inst_d = inst_i;
    end else if (pop) begin
      count_d     = count_q - 2'd1;
      head_addr_d = RST_ADDR;
      head_inst_d = NOP_INST;
`ifdef IF_ID_SKID_EN
      if (count_q == 2'd2) begin
        head_addr_d = tail_addr_q;
        head_inst_d = tail_inst_q;
      end
`endif
    end else if (push) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_addr_d = inst_addr_i;
        head_inst_d = inst_i;
      end
`ifdef IF_ID_SKID_EN
      else begin
        tail_addr_d = inst_addr_i;
        tail_inst_d = inst_i;
      end
`endif
    end
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      valid_q     <= 1'b0;
      head_addr_q <= RST_ADDR;
      head_inst_q <= NOP_INST;
`ifdef IF_ID_SKID_EN
      tail_addr_q <= 32'd0;
      tail_inst_q <= 32'd0;
`endif
    end else begin
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_addr_q <= head_addr_d;
      head_inst_q <= head_inst_d;
`ifdef IF_ID_SKID_EN
      tail_addr_q <= tail_addr_d;
      tail_inst_q <= tail_inst_d;
`endif
    end
  end

endmodule
